dct_1d_seq: RTL and testbench
=============================

DCT_1D_SEQ -- requirements
Module: dct_1d_seq

Interface
REQ-001 Parameters SHALL be, one per line:
- IN_W, 8, input sample width.
- COEF_W, 8, coefficient width including sign.
- OUT_W, 8, output coefficient width, signed.
- SHIFT, 11, right-shift applied to the accumulator.
- SIGNED_IN, 0, 0 = unsigned inputs (zero-extended), 1 = two's-complement inputs.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data holds a valid 8-sample vector.
- in_ready  out  1  block accepts a vector this cycle.
- in_data  in  8*IN_W  samples x0..x7, x0 in the MSBs.
- out_valid  out  1  out_data holds a valid result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  8*OUT_W  coefficients y0..y7, y0 in the MSBs.
- busy  out  1  high in COMPUTE.
REQ-003 The design SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-004 The FSM states SHALL be IDLE, COMPUTE and DONE.
REQ-005 An input handshake SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-006 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1, and 0 otherwise.
REQ-007 On the input handshake edge, in_data SHALL be captured, k SHALL be set to 0, and the FSM SHALL enter COMPUTE. Changes to in_data after capture SHALL have no effect.
REQ-008 In COMPUTE, each rising edge SHALL write y[k] to its out_data slot and increment k. After the edge that writes y7, the FSM SHALL go to DONE.
REQ-009 out_valid SHALL be 1 exactly in DONE, i.e. asserted 8 clock edges after the accepting edge.
REQ-010 out_valid and out_data SHALL stay stable in DONE until the edge where out_ready=1.
REQ-011 On a DONE edge with out_ready=1:
- with in_valid=0, the FSM SHALL go to IDLE;
- with in_valid=1, the new vector SHALL be captured and the FSM SHALL go directly to COMPUTE (sustained period 9 cycles).
REQ-012 y[k] SHALL equal sat_OUT_W((sum over n=0..7 of M[k][n]*x[n] + 2^(SHIFT-1)) >>> SHIFT), where >>> is an arithmetic shift (floor).
REQ-013 The coefficient matrix M SHALL be:
- M[0][n] = round(2^(COEF_W-1)*cos(pi/4));
- M[k][n] = round(2^(COEF_W-1)*cos((2n+1)*k*pi/16)) for k = 1..7.
- For COEF_W=8 the magnitudes SHALL be c1..c7 = 126, 118, 106, 91, 71, 49, 25.
REQ-014 The accumulator SHALL be signed and IN_W+COEF_W+4 bits wide, so that no internal overflow occurs for any input.
REQ-015 Each inner product SHALL be computed in one cycle using 8 parallel multipliers; rows SHALL be selected by k.
REQ-016 sat_OUT_W SHALL clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-017 out_data slots not yet rewritten in COMPUTE SHALL be don't-care to consumers; out_valid=0 marks them invalid.
REQ-018 busy SHALL be 1 iff the state is COMPUTE.

Reset
REQ-019 While rst=1:
- state = IDLE, k = 0, out_valid = 0, busy = 0, out_data = 0;
- the capture register SHALL be 0;
- in_ready SHALL be 0, then become 1 on the first cycle after deassertion.
REQ-020 Reset asserted in COMPUTE or DONE SHALL abort the transform immediately. No out_valid pulse SHALL follow, and the pending result SHALL be discarded.

Verification
REQ-021 Defaults, all x = 100 (0x64), out_ready=1 -> out_valid 8 edges after acceptance; y0 = 36 (0x24), y1..y7 = 0.
REQ-022 SIGNED_IN=1, x0 = 0x80 (-128), others 0 -> y0 = -6 (0xFA), y1 = -8 (0xF8), y7 = -2 (0xFE).
REQ-023 SHIFT=8, all x = 100 -> y0 saturates to 127 (0x7F); y1..y7 = 0.
REQ-024 out_ready held 0 for 5 cycles in DONE; in_valid=1 with new data -> out_valid and out_data stable, in_ready=0. When out_ready=1 with in_valid=1, the new vector is accepted on the same edge and the next out_valid follows 8 edges later.
REQ-025 rst pulsed on the 4th COMPUTE cycle -> out_valid stays 0 and outputs return to reset values. After release, a new vector = all 100 yields y0 = 36.
REQ-026 Random vectors (both SIGNED_IN values, random out_ready stalls) -> every y[k] matches the REQ-012 reference model bit-exactly; no vector is lost or duplicated.

Source files
------------

// File: rtl/dct_1d_seq.sv
// Sequential 8-point DCT-II: captures one vector, then produces one output
// coefficient per clock with eight parallel multipliers over the row selected by k.
module dct_1d_seq #(
    parameter int IN_W      = 8,
    parameter int COEF_W    = 8,
    parameter int OUT_W     = 8,
    parameter int SHIFT     = 11,
    parameter int SIGNED_IN = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*IN_W-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*OUT_W-1:0]   out_data,
    output logic                 busy
);

    localparam int ACC_W = IN_W + COEF_W + 4;
    localparam int PROD_W = IN_W + COEF_W + 1;

    // cos(m*pi/16) in Q30, rounded half-up to COEF_W-1 fractional bits.
    function automatic longint cos_mag(input int m);
        longint q;
        int     s;
        case (m)
            1:       q = 64'sd1053110176;
            2:       q = 64'sd992008094;
            3:       q = 64'sd892783698;
            4:       q = 64'sd759250125;
            5:       q = 64'sd596538995;
            6:       q = 64'sd410903207;
            7:       q = 64'sd209476638;
            default: q = 64'sd0;
        endcase
        s = 30 - (COEF_W - 1);
        return (q + (longint'(1) <<< (s - 1))) >>> s;
    endfunction

    // Row k, column n lives at slot k*8+n; signs come from the quadrant of (2n+1)k*pi/16.
    function automatic logic [64*COEF_W-1:0] build_coefs();
        logic [64*COEF_W-1:0] t;
        int     a;
        bit     neg;
        longint m;
        t = '0;
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 8; n++) begin
                neg = 1'b0;
                if (k == 0) begin
                    a = 4;
                end else begin
                    a = ((2 * n + 1) * k) % 32;
                    if (a > 8 && a <= 16) begin
                        a   = 16 - a;
                        neg = 1'b1;
                    end else if (a > 16 && a <= 24) begin
                        a   = a - 16;
                        neg = 1'b1;
                    end else if (a > 24) begin
                        a = 32 - a;
                    end
                end
                m = cos_mag(a);
                t[(k * 8 + n) * COEF_W +: COEF_W] = COEF_W'(neg ? -m : m);
            end
        end
        return t;
    endfunction

    localparam logic [64*COEF_W-1:0] COEFS = build_coefs();
    localparam logic signed [ACC_W-1:0] ROUND  = ACC_W'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                      state;
    logic [2:0]                  k;
    logic [8*IN_W-1:0]           x_reg;

    logic [IN_W-1:0]             xs   [8];
    logic signed [IN_W:0]        xe   [8];
    logic signed [COEF_W-1:0]    c    [8];
    logic signed [PROD_W-1:0]    prod [8];
    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_W-1:0]     shifted;
    logic signed [OUT_W-1:0]     y;

    // One full inner product per cycle for the row selected by k.
    always_comb begin
        acc = '0;
        for (int n = 0; n < 8; n++) begin
            xs[n]   = x_reg[(7 - n) * IN_W +: IN_W];
            xe[n]   = {((SIGNED_IN != 0) && xs[n][IN_W-1]), xs[n]};
            c[n]    = COEFS[(int'(k) * 8 + n) * COEF_W +: COEF_W];
            prod[n] = xe[n] * c[n];
            acc     = acc + ACC_W'(prod[n]);
        end
        shifted = (acc + ROUND) >>> SHIFT;
        if (shifted > SAT_HI)
            y = SAT_HI[OUT_W-1:0];
        else if (shifted < SAT_LO)
            y = SAT_LO[OUT_W-1:0];
        else
            y = shifted[OUT_W-1:0];
    end

    assign in_ready = ~rst & ((state == IDLE) | ((state == DONE) & out_ready));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            x_reg     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg <= in_data;
                        k     <= '0;
                        state <= COMPUTE;
                        busy  <= 1'b1;
                    end
                end
                COMPUTE: begin
                    out_data[(7 - int'(k)) * OUT_W +: OUT_W] <= y;
                    k <= k + 3'd1;
                    if (k == 3'd7) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                DONE: begin
                    // Releasing the result with a new vector waiting skips IDLE entirely.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            x_reg <= in_data;
                            k     <= '0;
                            state <= COMPUTE;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dct_1d_seq.sv
// Directed bench for dct_1d_seq: three instances (default, signed input, SHIFT=8)
// share one stimulus stream and are checked against hand values and a reference model.
module tb_dct_1d_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;
    logic [2:0]  in_ready_v;
    logic [2:0]  out_valid_v;
    logic [2:0]  busy_v;
    logic [63:0] out_data_0;
    logic [63:0] out_data_1;
    logic [63:0] out_data_2;

    int checks = 0;
    int errors = 0;

    localparam int M [0:7][0:7] = '{
        '{ 91,   91,   91,   91,   91,   91,   91,   91},
        '{126,  106,   71,   25,  -25,  -71, -106, -126},
        '{118,   49,  -49, -118, -118,  -49,   49,  118},
        '{106,  -25, -126,  -71,   71,  126,   25, -106},
        '{ 91,  -91,  -91,   91,   91,  -91,  -91,   91},
        '{ 71, -126,   25,  106, -106,  -25,  126,  -71},
        '{ 49, -118,  118,  -49,  -49,  118, -118,   49},
        '{ 25,  -71,  106, -126,  126, -106,   71,  -25}
    };

    dct_1d_seq u_def (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .in_data(in_data), .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .out_data(out_data_0), .busy(busy_v[0])
    );

    dct_1d_seq #(.SIGNED_IN(1)) u_sgn (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .in_data(in_data), .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .out_data(out_data_1), .busy(busy_v[1])
    );

    dct_1d_seq #(.SHIFT(8)) u_sh8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .in_data(in_data), .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .out_data(out_data_2), .busy(busy_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] model(input logic [63:0] x, input bit sgn, input int shift);
        logic [63:0] r;
        logic [7:0]  s;
        int          acc;
        int          xv;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            acc = 0;
            for (int n = 0; n < 8; n++) begin
                s   = x[(7 - n) * 8 +: 8];
                xv  = sgn ? int'($signed(s)) : int'(s);
                acc = acc + M[k][n] * xv;
            end
            acc = (acc + (1 << (shift - 1))) >>> shift;
            if (acc > 127) acc = 127;
            if (acc < -128) acc = -128;
            r[(7 - k) * 8 +: 8] = acc[7:0];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int expect_edges);
        int edges;
        edges = 0;
        while (out_valid_v !== 3'b111 && edges < 32) begin
            tick();
            edges++;
        end
        check_output({tag, "_latency"}, 64'(edges), 64'(expect_edges));
    endtask

    task automatic check_all(input string tag, input logic [63:0] x);
        check_output({tag, "_def"}, out_data_0, model(x, 1'b0, 11));
        check_output({tag, "_sgn"}, out_data_1, model(x, 1'b1, 11));
        check_output({tag, "_sh8"}, out_data_2, model(x, 1'b0, 8));
    endtask

    // Present a vector from IDLE, wait for the result, stall, then release it.
    task automatic apply_vector(input string tag, input logic [63:0] x, input int stall);
        in_data   = x;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        wait_valid(tag, 8);
        check_all(tag, x);
        for (int i = 0; i < stall; i++) begin
            tick();
            check_output({tag, "_stall_data"}, out_data_0, model(x, 1'b0, 11));
        end
        out_ready = 1'b1;
        tick();
        check_output({tag, "_release"}, {61'd0, out_valid_v}, 64'd0);
    endtask

    logic [63:0] vec_a;
    logic [63:0] vec_b;
    logic        seen_valid;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        tick();
        check_output("reset_valid", {61'd0, out_valid_v}, 64'd0);
        check_output("reset_busy", {61'd0, busy_v}, 64'd0);
        check_output("reset_ready", {61'd0, in_ready_v}, 64'd0);
        check_output("reset_data", out_data_0 | out_data_1 | out_data_2, 64'd0);
        rst = 1'b0;
        #1;
        check_output("ready_after_reset", {61'd0, in_ready_v}, 64'h7);

        // All samples 100: only the DC term survives.
        in_data  = 64'h6464646464646464;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = 64'hFFFFFFFFFFFFFFFF;
        check_output("compute_busy", {61'd0, busy_v}, 64'h7);
        check_output("compute_ready", {61'd0, in_ready_v}, 64'd0);
        wait_valid("dc100", 8);
        check_output("dc100_def", out_data_0, 64'h2400000000000000);
        check_output("dc100_sgn", out_data_1, 64'h2400000000000000);
        check_output("dc100_sh8_sat", out_data_2, 64'h7F00000000000000);
        tick();
        check_output("dc100_idle_valid", {61'd0, out_valid_v}, 64'd0);
        check_output("dc100_idle_ready", {61'd0, in_ready_v}, 64'h7);

        // Impulse at x0 = 0x80: negative in the signed instance.
        in_data  = 64'h8000000000000000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid("impulse", 8);
        check_output("impulse_def", out_data_0, 64'h0608070706040302);
        check_output("impulse_sgn", out_data_1, 64'hFAF8F9F9FAFCFDFE);
        check_output("impulse_sh8", out_data_2, 64'h2E3F3B352E24190D);
        tick();

        // Backpressure in DONE with a new vector already waiting.
        vec_a     = 64'h0A141E28323C4650;
        vec_b     = 64'hFF00FF00FF00FF00;
        out_ready = 1'b0;
        in_data   = vec_a;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid("stall_a", 8);
        in_data  = vec_b;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("stall_valid", {61'd0, out_valid_v}, 64'h7);
            check_output("stall_ready", {61'd0, in_ready_v}, 64'd0);
            check_all("stall_a", vec_a);
        end
        out_ready = 1'b1;
        #1;
        check_output("release_ready", {61'd0, in_ready_v}, 64'h7);
        tick();
        in_valid = 1'b0;
        in_data  = 64'h0123456789ABCDEF;
        check_output("b2b_valid_drop", {61'd0, out_valid_v}, 64'd0);
        check_output("b2b_busy", {61'd0, busy_v}, 64'h7);
        wait_valid("b2b", 8);
        check_all("b2b", vec_b);
        tick();

        // Reset during the 4th COMPUTE cycle discards the transform.
        in_data  = 64'h6464646464646464;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_output("abort_valid", {61'd0, out_valid_v}, 64'd0);
        check_output("abort_busy", {61'd0, busy_v}, 64'd0);
        check_output("abort_ready", {61'd0, in_ready_v}, 64'd0);
        check_output("abort_data", out_data_0 | out_data_1 | out_data_2, 64'd0);
        tick();
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid_v != 3'b000) seen_valid = 1'b1;
        end
        check_output("abort_no_valid", {63'd0, seen_valid}, 64'd0);
        in_data  = 64'h6464646464646464;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid("post_abort", 8);
        check_output("post_abort_def", out_data_0, 64'h2400000000000000);
        tick();

        // Random vectors with random stalls in DONE.
        for (int i = 0; i < 8; i++) begin
            apply_vector("rand", {$urandom, $urandom}, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
